// File: rtl/regfile_rd_port.sv
// Register file with one synchronous write port and two registered read ports.
// Each read port has a write-through bypass. Stall holds the output stage.
// Reads of an index >= NREGS return zero. With ZERO_R0=1, register 0 reads as zero.
module regfile_rd_port #(
  parameter int DATA_W  = 16,
  parameter int NREGS   = 16,
  parameter bit ZERO_R0 = 1'b0,
  localparam int SEL_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid_in,
  input  logic [SEL_W-1:0]  rd_sel_a,
  input  logic [SEL_W-1:0]  rd_sel_b,
  input  logic              stall,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid_out
);

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_ok;
  logic [DATA_W-1:0] sel_val_a;
  logic [DATA_W-1:0] sel_val_b;
  logic              accept;

  // The register index must be in range. Register 0 is read-only when it is hardwired to zero.
  function automatic logic sel_in_range(input logic [SEL_W-1:0] s);
    return int'(s) < NREGS;
  endfunction

  // Selected value, in priority order: out of range, then hardwired zero, then bypass, then the array.
  function automatic logic [DATA_W-1:0] sel_value(input logic [SEL_W-1:0] s);
    logic [DATA_W-1:0] v;
    v = '0;
    if (!sel_in_range(s))
      v = '0;
    else if (ZERO_R0 && (s == '0))
      v = '0;
    else if (wr_en && (wr_sel == s))
      v = wr_data;
    else
      v = regs[s];
    return v;
  endfunction

  // Qualify the write strobe. Writes are dropped for an out-of-range index and for a hardwired r0.
  always_comb begin
    wr_ok = wr_en && sel_in_range(wr_sel) && !(ZERO_R0 && (wr_sel == '0));
  end

  // Read-port selectors with write-through bypass
  always_comb begin
    sel_val_a = sel_value(rd_sel_a);
    sel_val_b = sel_value(rd_sel_b);
    accept    = rd_valid_in && !stall;
  end

  // Register array. Writes ignore stall, and reset clears every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wr_sel] <= wr_data;
    end
  end

  // Output stage. It captures data on an accepted request and drops valid when idle.
  // Stall freezes the whole stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_a    <= '0;
      rd_data_b    <= '0;
      rd_valid_out <= 1'b0;
    end else if (!stall) begin
      if (accept) begin
        rd_data_a    <= sel_val_a;
        rd_data_b    <= sel_val_b;
        rd_valid_out <= 1'b1;
      end else begin
        rd_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_rd_port.sv
// Bench for regfile_rd_port. It runs three configurations in lockstep:
// the default, ZERO_R0=1, and NREGS=12.
// An array-level reference model predicts every output on every cycle.
// Literal checks pin the key scenarios.
module tb_regfile_rd_port;

  logic        clk = 1'b0;
  logic        rst, wr_en, rd_valid_in, stall;
  logic [3:0]  wr_sel, rd_sel_a, rd_sel_b;
  logic [15:0] wr_data;

  logic [15:0] da [3];
  logic [15:0] db [3];
  logic        dv [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_rd_port #(.DATA_W(16), .NREGS(16), .ZERO_R0(1'b0)) u_def (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_valid_in(rd_valid_in), .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .stall(stall),
    .rd_data_a(da[0]), .rd_data_b(db[0]), .rd_valid_out(dv[0]));

  regfile_rd_port #(.DATA_W(16), .NREGS(16), .ZERO_R0(1'b1)) u_z0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_valid_in(rd_valid_in), .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .stall(stall),
    .rd_data_a(da[1]), .rd_data_b(db[1]), .rd_valid_out(dv[1]));

  regfile_rd_port #(.DATA_W(16), .NREGS(12), .ZERO_R0(1'b0)) u_n12 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_valid_in(rd_valid_in), .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .stall(stall),
    .rd_data_a(da[2]), .rd_data_b(db[2]), .rd_valid_out(dv[2]));

  // Reference model
  int          cfg_nregs [3] = '{16, 16, 12};
  bit          cfg_zr0   [3] = '{1'b0, 1'b1, 1'b0};
  logic [15:0] mem   [3][16];
  logic [15:0] exp_a [3];
  logic [15:0] exp_b [3];
  logic        exp_v [3];
  bit          started = 1'b0;

  function automatic logic [15:0] model_read(input int k, input int s);
    if (s >= cfg_nregs[k]) return 16'h0000;
    if (cfg_zr0[k] && s == 0) return 16'h0000;
    if (wr_en && int'(wr_sel) == s) return wr_data;
    return mem[k][s];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int r = 0; r < 16; r++) mem[k][r] = 16'h0000;
        exp_a[k] = 16'h0000;
        exp_b[k] = 16'h0000;
        exp_v[k] = 1'b0;
      end else begin
        if (!stall) begin
          if (rd_valid_in) begin
            exp_a[k] = model_read(k, int'(rd_sel_a));
            exp_b[k] = model_read(k, int'(rd_sel_b));
            exp_v[k] = 1'b1;
          end else begin
            exp_v[k] = 1'b0;
          end
        end
        if (wr_en && int'(wr_sel) < cfg_nregs[k] && !(cfg_zr0[k] && wr_sel == 4'd0))
          mem[k][wr_sel] = wr_data;
      end
    end
    if (rst) started = 1'b1;
  end

  // Compare process: every configuration, every cycle after the first reset
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (dv[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL model_valid cfg%0d t=%0t got %b want %b", k, $time, dv[k], exp_v[k]);
        end
        checks++;
        if (da[k] !== exp_a[k]) begin
          errors++;
          $display("FAIL model_data_a cfg%0d t=%0t got %h want %h", k, $time, da[k], exp_a[k]);
        end
        checks++;
        if (db[k] !== exp_b[k]) begin
          errors++;
          $display("FAIL model_data_b cfg%0d t=%0t got %h want %h", k, $time, db[k], exp_b[k]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the rising edge
  task automatic cyc(input logic r, input logic we, input logic [3:0] ws, input logic [15:0] wd,
                     input logic vin, input logic [3:0] sa, input logic [3:0] sb, input logic st);
    rst = r; wr_en = we; wr_sel = ws; wr_data = wd;
    rd_valid_in = vin; rd_sel_a = sa; rd_sel_b = sb; stall = st;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_valid", {15'd0, dv[0]}, 16'h0000);
    chk("reset_data_a", da[0], 16'h0000);

    // Reset clears the array
    cyc(0, 1, 4'd5, 16'hBEEF, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 4'd5, 4'd5, 0);
    chk("pre_reset_r5", da[0], 16'hBEEF);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_valid2", {15'd0, dv[0]}, 16'h0000);
    chk("reset_data_b", db[0], 16'h0000);
    cyc(0, 0, 0, 0, 1, 4'd5, 4'd5, 0);
    chk("post_reset_r5", da[0], 16'h0000);

    // Write all registers, then read pairs back-to-back
    for (int i = 0; i < 16; i++) cyc(0, 1, 4'(i), 16'h1000 + 16'(i), 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 0, 1, 4'(i), 4'(15 - i), 0);
      chk("rdall_a", da[0], 16'h1000 + 16'(i));
      chk("rdall_b", db[0], 16'h1000 + 16'(15 - i));
      chk("rdall_valid", {15'd0, dv[0]}, 16'h0001);
    end
    chk("z0_r0", da[1], 16'h1000 + 16'd15);
    chk("n12_sel15_zero", da[2], 16'h0000);

    // Same-cycle bypass onto a cleared r3
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 4'd3, 16'hA5A5, 1, 4'd3, 4'd3, 0);
    chk("bypass_a", da[0], 16'hA5A5);
    chk("bypass_b", db[0], 16'hA5A5);

    // A stall holds the old r2 value while r2 is rewritten
    cyc(0, 1, 4'd2, 16'h0022, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 4'd2, 4'd2, 0);
    chk("stall_pre", da[0], 16'h0022);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 4'd2, 16'h7777, 1, 4'd2, 4'd2, 1);
      chk("stall_hold_a", da[0], 16'h0022);
      chk("stall_hold_valid", {15'd0, dv[0]}, 16'h0001);
    end
    cyc(0, 0, 0, 0, 1, 4'd2, 4'd2, 0);
    chk("stall_reread", da[0], 16'h7777);

    // Idle drops valid and holds the data
    cyc(0, 0, 0, 0, 0, 4'd9, 4'd9, 0);
    chk("idle_valid", {15'd0, dv[0]}, 16'h0000);
    chk("idle_hold", da[0], 16'h7777);

    // r0 is hardwired to zero, including when written in the same cycle
    cyc(0, 1, 4'd0, 16'hFFFF, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 4'd0, 4'd0, 0);
    chk("z0_read_a", da[1], 16'h0000);
    chk("z0_read_b", db[1], 16'h0000);
    chk("def_r0", da[0], 16'hFFFF);
    cyc(0, 1, 4'd0, 16'h1234, 1, 4'd0, 4'd0, 0);
    chk("z0_no_bypass", da[1], 16'h0000);
    chk("def_r0_bypass", da[0], 16'h1234);

    // NREGS=12: out-of-range reads return zero, and out-of-range writes are dropped
    cyc(0, 1, 4'd6, 16'h0606, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 4'd13, 4'd6, 0);
    chk("n12_oor_read", da[2], 16'h0000);
    chk("n12_r6", db[2], 16'h0606);
    cyc(0, 1, 4'd14, 16'hDEAD, 1, 4'd14, 4'd2, 0);
    chk("n12_oor_bypass", da[2], 16'h0000);
    chk("def_r14_bypass", da[0], 16'hDEAD);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 1, 4'(i), 4'(11 - i), 0);
    cyc(0, 0, 0, 0, 1, 4'd2, 4'd6, 0);
    chk("n12_r2_kept", da[2], 16'h7777);
    chk("n12_r6_kept", db[2], 16'h0606);

    // Reset mid-stream loses the pending request
    cyc(1, 0, 0, 0, 1, 4'd6, 4'd6, 0);
    chk("midrst_valid", {15'd0, dv[0]}, 16'h0000);
    chk("midrst_data", da[0], 16'h0000);
    cyc(0, 0, 0, 0, 1, 4'd6, 4'd6, 0);
    chk("midrst_reissue", da[0], 16'h0000);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
